// File: rtl/punc_mem_arbiter_pkg.sv
// PUnC memory arbiter shared definitions.
// FSM state and owner encodings plus the wait-count helper.
package punc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    // Wait-state count loaded in ISSUE for a given read latency
    function automatic logic [1:0] wait_load(input int unsigned lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/punc_rr_pick.sv
// Two-way round-robin picker for the PUnC memory arbiter.
// On a tie the requester that was not served last wins.
module punc_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pick a winner among the active requests
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = 1'b0;
        if (req0 && req1) begin
            gnt_id = ~last;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/punc_mem_arbiter.sv
// PUnC unified-memory arbiter: core and host share one memory port.
// Serialised req/ack transactions, round-robin on ties, host lock.
module punc_mem_arbiter
    import punc_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              h_lock,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_cnt;
    logic              r_last;
    logic              r_c_ack;
    logic              r_h_ack;
    logic              r_m_en;
    logic              r_m_we;
    logic              r_busy;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_h_rdata;

    logic              w_c_elig;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_grant;
    logic              w_m_en_d;
    logic              w_m_we_d;
    logic              w_c_ack_d;
    logic              w_h_ack_d;
    logic              w_busy_d;

    // Lock keeps the core out of arbitration entirely
    assign w_c_elig = c_req & ~h_lock;

    punc_rr_pick u_pick (
        .req0      (w_c_elig),
        .req1      (h_req),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    assign w_gnt_we    = (w_gnt_id == OWN_HOST) ? h_we    : c_we;
    assign w_gnt_addr  = (w_gnt_id == OWN_HOST) ? h_addr  : c_addr;
    assign w_gnt_wdata = (w_gnt_id == OWN_HOST) ? h_wdata : c_wdata;
    assign w_grant     = (r_state == ARB_IDLE) && w_gnt_valid;

    // Next state and next registered output values
    always_comb begin
        w_next    = r_state;
        unique case (r_state)
            ARB_IDLE:  if (w_gnt_valid) w_next = ARB_ISSUE;
            ARB_ISSUE: w_next = (MEM_LAT <= 1) ? ARB_DONE : ARB_WAIT;
            ARB_WAIT:  if (r_cnt <= 2'd1) w_next = ARB_DONE;
            ARB_DONE:  w_next = ARB_IDLE;
        endcase
        w_m_en_d  = (w_next == ARB_ISSUE);
        w_m_we_d  = w_grant & w_gnt_we;
        w_c_ack_d = (w_next == ARB_DONE) && (r_owner == OWN_CORE);
        w_h_ack_d = (w_next == ARB_DONE) && (r_owner == OWN_HOST);
        w_busy_d  = (w_next != ARB_IDLE);
    end

    // State register and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_m_en  <= 1'b0;
            r_m_we  <= 1'b0;
            r_c_ack <= 1'b0;
            r_h_ack <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_m_en  <= w_m_en_d;
            r_m_we  <= w_m_we_d;
            r_c_ack <= w_c_ack_d;
            r_h_ack <= w_h_ack_d;
            r_busy  <= w_busy_d;
        end
    end

    // Latch the granted transaction; address/data hold afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= OWN_CORE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_gnt_id;
            r_we    <= w_gnt_we;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_wdata;
        end
    end

    // Read-latency wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 2'd0;
        end else if (r_state == ARB_ISSUE) begin
            r_cnt <= wait_load(MEM_LAT);
        end else if (r_state == ARB_WAIT) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    // Capture read data and record the owner on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last    <= OWN_HOST;
            r_c_rdata <= '0;
            r_h_rdata <= '0;
        end else if (w_next == ARB_DONE) begin
            r_last <= r_owner;
            if (!r_we && r_owner == OWN_HOST) begin
                r_h_rdata <= m_rdata;
            end
            if (!r_we && r_owner == OWN_CORE) begin
                r_c_rdata <= m_rdata;
            end
        end
    end

    assign c_ack   = r_c_ack;
    assign h_ack   = r_h_ack;
    assign c_rdata = r_c_rdata;
    assign h_rdata = r_h_rdata;
    assign m_en    = r_m_en;
    assign m_we    = r_m_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter.
// Two instances: MEM_LAT=1 (main) and MEM_LAT=3 (reset-abort case).
module tb_punc_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c_req, c_we, c_ack;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic        h_req, h_we, h_ack, h_lock;
    logic [15:0] h_addr, h_wdata, h_rdata;
    logic        m_en, m_we, busy;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata = 16'hDEAD;

    logic        x_rst;
    logic        x_c_req, x_c_we, x_c_ack;
    logic [15:0] x_c_addr, x_c_wdata, x_c_rdata;
    logic        x_h_req, x_h_we, x_h_ack, x_h_lock;
    logic [15:0] x_h_addr, x_h_wdata, x_h_rdata;
    logic        x_m_en, x_m_we, x_busy;
    logic [15:0] x_m_addr, x_m_wdata;
    logic [15:0] x_m_rdata = 16'hDEAD;
    logic [1:0]  x_hist = 2'b00;

    punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata), .h_lock(h_lock),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(x_rst),
        .c_req(x_c_req), .c_we(x_c_we), .c_addr(x_c_addr), .c_wdata(x_c_wdata),
        .c_ack(x_c_ack), .c_rdata(x_c_rdata),
        .h_req(x_h_req), .h_we(x_h_we), .h_addr(x_h_addr), .h_wdata(x_h_wdata),
        .h_ack(x_h_ack), .h_rdata(x_h_rdata), .h_lock(x_h_lock),
        .m_en(x_m_en), .m_we(x_m_we), .m_addr(x_m_addr), .m_wdata(x_m_wdata),
        .m_rdata(x_m_rdata), .busy(x_busy)
    );

    // Memory device for the MEM_LAT=1 instance
    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h3000) ? 16'hBEEF : 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr] = m_wdata;
    end

    always @(negedge clk) begin
        if (m_en) m_rdata = mem.exists(m_addr) ? mem[m_addr] : init_val(m_addr);
        else      m_rdata = 16'hDEAD;
    end

    // Memory device for the MEM_LAT=3 instance: data only in its slot
    always @(posedge clk) x_hist <= {x_hist[0], x_m_en};

    always @(negedge clk) begin
        x_m_rdata = x_hist[1] ? (x_m_addr ^ 16'hC3C3) : 16'hDEAD;
    end

    typedef struct {
        bit          own;
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        bit          own;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rexp;
    } vec_t;

    sb_t         q[$];
    vec_t        tbl[9];
    logic [15:0] shadow [logic [15:0]];
    logic [15:0] exp_c_rd = 16'h0;
    logic [15:0] exp_h_rd = 16'h0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic push(input bit own, input bit we,
                        input logic [15:0] a, input logic [15:0] d);
        sb_t e;
        e.own = own; e.we = we; e.addr = a; e.data = d;
        q.push_back(e);
        if (we)       shadow[a] = d;
        else if (own) exp_h_rd = d;
        else          exp_c_rd = d;
    endtask

    // One clock, then per-cycle monitoring and scoreboard pop
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (c_ack || h_ack) begin
            chk("one_ack_per_cycle", 32'(c_ack & h_ack), 32'd0);
            chk("ack_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ack_owner", 32'(h_ack), 32'(e.own));
                if (!e.we) begin
                    chk("ack_rdata", 32'(e.own ? h_rdata : c_rdata), 32'(e.data));
                end
            end
        end
        if (m_we) chk("m_we_with_m_en", 32'(m_en), 32'd1);
        if (x_c_ack) chk("lat3_core_ack_after_abort", 32'(x_c_ack), 32'd0);
    endtask

    task automatic wait_acks(input int n);
        int cnt = 0;
        int k = 0;
        while (cnt < n && k < 200) begin
            tick();
            if (c_ack || h_ack) cnt++;
            k++;
        end
        chk("acks_seen", 32'(cnt), 32'(n));
    endtask

    task automatic run_txn(input bit own, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] rexp);
        int k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        if (own) begin
            h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
        end
        push(own, we, a, we ? wd : rexp);
        tick();
        chk("issue_m_en", 32'(m_en), 32'd1);
        chk("issue_m_addr", 32'(m_addr), 32'(a));
        chk("issue_m_we", 32'(m_we), 32'(we));
        if (we) chk("issue_m_wdata", 32'(m_wdata), 32'(wd));
        k = 1;
        while (!(c_ack || h_ack) && k < 12) begin
            tick();
            k++;
        end
        chk("ack_latency", 32'(k), 32'd2);
        c_req = 1'b0;
        h_req = 1'b0;
        chk("c_rdata_hold", 32'(c_rdata), 32'(exp_c_rd));
        chk("h_rdata_hold", 32'(h_rdata), 32'(exp_h_rd));
    endtask

    initial begin
        int k;
        tbl[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 16'h5A5A, 16'h0000};
        tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};

        rst = 1'b0; x_rst = 1'b0; h_lock = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h3000; c_wdata = 16'h0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0040; h_wdata = 16'h0;
        x_c_req = 1'b0; x_c_we = 1'b0; x_c_addr = 16'h0; x_c_wdata = 16'h0;
        x_h_req = 1'b0; x_h_we = 1'b0; x_h_addr = 16'h0; x_h_wdata = 16'h0;
        x_h_lock = 1'b0;

        // Reset with both requests pending
        tick();
        tick();
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_c_ack", 32'(c_ack), 32'd0);
        chk("rst_h_ack", 32'(h_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c_rdata", 32'(c_rdata), 32'd0);
        chk("rst_h_rdata", 32'(h_rdata), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_lat3_busy", 32'(x_busy), 32'd0);
        push(1'b0, 1'b0, 16'h3000, shadow_rd(16'h3000));
        push(1'b1, 1'b0, 16'h0040, shadow_rd(16'h0040));
        rst = 1'b1;
        x_rst = 1'b1;
        wait_acks(2);
        c_req = 1'b0;
        h_req = 1'b0;

        // Single transactions with exact latency
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].own, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rexp);
        end

        // Both held: strict alternation starting with the core
        c_we = 1'b0; c_addr = 16'h3000;
        h_we = 1'b0; h_addr = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, 16'h3000, shadow_rd(16'h3000));
            push(1'b1, 1'b0, 16'h0040, shadow_rd(16'h0040));
        end
        c_req = 1'b1;
        h_req = 1'b1;
        wait_acks(8);
        c_req = 1'b0;
        h_req = 1'b0;

        // Host lock starves the core
        h_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 1'b0, 16'h0040, shadow_rd(16'h0040));
        end
        c_req = 1'b1;
        h_req = 1'b1;
        wait_acks(3);
        h_req = 1'b0;
        tick();
        tick();
        tick();
        chk("lock_idle_busy", 32'(busy), 32'd0);
        chk("lock_idle_m_en", 32'(m_en), 32'd0);
        push(1'b0, 1'b0, 16'h3000, shadow_rd(16'h3000));
        push(1'b1, 1'b0, 16'h0040, shadow_rd(16'h0040));
        h_lock = 1'b0;
        h_req = 1'b1;
        wait_acks(2);
        c_req = 1'b0;
        h_req = 1'b0;
        chk("sb_drained", 32'(q.size()), 32'd0);

        // MEM_LAT=3: reset during WAIT abandons the core read
        x_c_req = 1'b1;
        x_c_addr = 16'h3000;
        tick();
        chk("lat3_issue_m_en", 32'(x_m_en), 32'd1);
        tick();
        chk("lat3_wait_busy", 32'(x_busy), 32'd1);
        x_rst = 1'b0;
        x_c_req = 1'b0;
        tick();
        chk("lat3_rst_busy", 32'(x_busy), 32'd0);
        chk("lat3_rst_m_en", 32'(x_m_en), 32'd0);
        x_rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("lat3_c_rdata", 32'(x_c_rdata), 32'd0);
        x_h_req = 1'b1;
        x_h_addr = 16'h0040;
        tick();
        k = 1;
        while (!x_h_ack && k < 12) begin
            tick();
            k++;
        end
        chk("lat3_host_latency", 32'(k), 32'd4);
        chk("lat3_h_rdata", 32'(x_h_rdata), 32'h0000C383);
        x_h_req = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
